bsg_manycore_reset_sequencer: RTL

BSG_MANYCORE_RESET_SEQUENCER -- requirements
Module: bsg_manycore_reset_sequencer

---
 rtl/bsg_manycore_reset_sequencer_pkg.sv | 24 ++
 rtl/bsg_manycore_reset_sequencer_domain.sv | 44 ++++
 rtl/bsg_manycore_reset_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bsg_manycore_reset_sequencer_pkg.sv
// Shared types for the manycore reset sequencer: FSM state encoding and sizing helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bsg_manycore_reset_sequencer_pkg;

  // State encoding is also the value seen on state_o, so host-side decode must match.
  typedef enum logic [2:0] {
    eHold  = 3'd0,
    eTag   = 3'd1,
    eDelay = 3'd2,
    eRun   = 3'd3,
    eFail  = 3'd4
  } state_e;

  // Width that can hold values 0..x-1, never narrower than one bit.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_manycore_reset_sequencer_domain.sv
// One domain: staggered reset release plus sticky tag-programming-done capture.
// Latency: release registered on the edge the shared counter hits this domain's offset; seen one edge after tag_done.
// Backpressure: none; tag_done_i is a level sampled every cycle, ignored while the domain is held.
module bsg_manycore_reset_sequencer_domain
  import bsg_manycore_reset_sequencer_pkg::*;
#(
  parameter int cnt_width_p = 1,
  parameter int offset_p    = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   tag_window_i,
  input  logic [cnt_width_p-1:0] cnt_next_i,
  input  logic                   tag_done_i,
  output logic                   domain_reset_o,
  output logic                   seen_next_o
);

  localparam logic [cnt_width_p-1:0] offset_lp = cnt_width_p'(offset_p);

  logic domain_reset_r;
  logic seen_r;
  logic release_now;

  // Release when the tag-phase counter is about to show this domain's offset.
  assign release_now = tag_window_i && (cnt_next_i == offset_lp);

  // Tag done only counts once this domain is already out of reset.
  assign seen_next_o = seen_r | (~domain_reset_r & tag_done_i);

  // Release and seen are both sticky until the global reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      domain_reset_r <= 1'b1;
      seen_r         <= 1'b0;
    end else begin
      domain_reset_r <= domain_reset_r & ~release_now;
      seen_r         <= seen_next_o;
    end
  end

  assign domain_reset_o = domain_reset_r;

endmodule

// File: rtl/bsg_manycore_reset_sequencer.sv
// Sequences pod/testbench domain resets, waits for tag programming, then releases the host.
// Latency: hold_cycles_p after reset_i falls, up to timeout_p waiting for tags, then done_delay_p before host release.
// Backpressure: none; tag_done_i levels are sampled every cycle and the FSM never stalls its inputs.
module bsg_manycore_reset_sequencer
  import bsg_manycore_reset_sequencer_pkg::*;
#(
  parameter int num_domains_p = 1,
  parameter int hold_cycles_p = 16,
  parameter int stagger_p     = 0,
  parameter int done_delay_p  = 3,
  parameter int timeout_p     = 65535
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [num_domains_p-1:0] tag_done_i,
  output logic [num_domains_p-1:0] domain_reset_o,
  output logic                     host_reset_o,
  output logic                     done_o,
  output logic                     timeout_o,
  output logic [2:0]               state_o
);

  // One shared counter serves every phase; sized for the longest phase or stagger span.
  localparam int span_lp = max2(max2(hold_cycles_p, done_delay_p),
                                max2(timeout_p, (num_domains_p - 1) * stagger_p + 1));
  localparam int cnt_width_lp = safe_clog2(span_lp);

  localparam logic [cnt_width_lp-1:0] hold_last_lp  = cnt_width_lp'(hold_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] tag_last_lp   = cnt_width_lp'(timeout_p - 1);
  localparam logic [cnt_width_lp-1:0] delay_last_lp =
    cnt_width_lp'((done_delay_p > 0) ? (done_delay_p - 1) : 0);
  localparam logic [cnt_width_lp-1:0] one_lp        = cnt_width_lp'(1);

  state_e                    state_r, state_n;
  logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
  logic [num_domains_p-1:0]  seen_next;
  logic                      all_seen_n;
  logic                      host_reset_n, done_n, timeout_n;
  logic                      host_reset_r, done_r, timeout_r;

  // Includes tags that land this very cycle, so a last-moment tag beats the timeout.
  assign all_seen_n = &seen_next;

  for (genvar i = 0; i < num_domains_p; i++) begin : dom
    bsg_manycore_reset_sequencer_domain #(
      .cnt_width_p(cnt_width_lp),
      .offset_p   (i * stagger_p)
    ) domain (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .tag_window_i  (state_n == eTag),
      .cnt_next_i    (cnt_n),
      .tag_done_i    (tag_done_i[i]),
      .domain_reset_o(domain_reset_o[i]),
      .seen_next_o   (seen_next[i])
    );
  end

  // State, phase counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= eHold;
      cnt_r        <= '0;
      host_reset_r <= 1'b1;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      host_reset_r <= host_reset_n;
      done_r       <= done_n;
      timeout_r    <= timeout_n;
    end
  end

  // Next state: each phase counts from zero and restarts the counter on exit.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      eHold: begin
        if (cnt_r == hold_last_lp) begin
          state_n = eTag;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + one_lp;
        end
      end
      eTag: begin
        if (all_seen_n) begin
          state_n = (done_delay_p == 0) ? eRun : eDelay;
          cnt_n   = '0;
        end else if (cnt_r == tag_last_lp) begin
          state_n = eFail;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + one_lp;
        end
      end
      eDelay: begin
        if (cnt_r == delay_last_lp) begin
          state_n = eRun;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + one_lp;
        end
      end
      default: begin
        state_n = state_r;
        cnt_n   = cnt_r;
      end
    endcase
  end

  // Outputs follow the next state so they change on the same edge as the state.
  always_comb begin
    host_reset_n = (state_n != eRun);
    done_n       = (state_n == eRun);
    timeout_n    = (state_n == eFail);
  end

  assign host_reset_o = host_reset_r;
  assign done_o       = done_r;
  assign timeout_o    = timeout_r;
  assign state_o      = state_r;

endmodule
